// File: rtl/sdes_pkg.sv
// sdes_pkg: shared S-DES state type, S-boxes, permutations and key schedule
package sdes_pkg;

    typedef enum logic [1:0] {IDLE, RND1, RND2, OUT} state_t;

    localparam logic [1:0] S0 [4][4] = '{
        '{2'd1, 2'd0, 2'd3, 2'd2},
        '{2'd3, 2'd2, 2'd1, 2'd0},
        '{2'd0, 2'd2, 2'd1, 2'd3},
        '{2'd3, 2'd1, 2'd3, 2'd2}
    };

    localparam logic [1:0] S1 [4][4] = '{
        '{2'd0, 2'd1, 2'd2, 2'd3},
        '{2'd2, 2'd0, 2'd1, 2'd3},
        '{2'd3, 2'd0, 2'd1, 2'd0},
        '{2'd2, 2'd1, 2'd0, 2'd3}
    };

    // Bit n of an S-DES word (MSB-first, 1-based) lives at index width-n.
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] k);
        return {k[8:5], k[9], k[3:0], k[4]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [7:0] k1_of(input logic [9:0] key);
        return p8(ls1(p10(key)));
    endfunction

    function automatic logic [7:0] k2_of(input logic [9:0] key);
        return p8(ls1(ls1(ls1(p10(key)))));
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// sdes_fk: combinational S-DES round function fK (left half mixed, right half passed)
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] data,
    input  logic [7:0] subkey,
    output logic [7:0] res
);
    logic [7:0] t;
    logic [1:0] a, b;
    assign t   = ep(data[3:0]) ^ subkey;
    assign a   = S0[{t[7], t[4]}][{t[6], t[5]}];
    assign b   = S1[{t[3], t[0]}][{t[2], t[1]}];
    assign res = {data[7:4] ^ p4({a, b}), data[3:0]};
endmodule

// File: rtl/sdes_dec_iter.sv
// sdes_dec_iter: iterative S-DES decryptor, one shared fK over two rounds
module sdes_dec_iter
    import sdes_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] i_key,
    input  logic [7:0] i_cipher_text,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_pln_txt,
    output logic       o_valid,
    input  logic       i_ready
);
    state_t     state;
    logic [7:0] data, k1, k2, fk_res;
    assign o_ready = state == IDLE;
    // Decryption runs the key schedule backwards: K2 in the first round.
    sdes_fk u_fk (.data(data), .subkey(state == RND1 ? k2 : k1), .res(fk_res));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            data      <= '0;
            k1        <= '0;
            k2        <= '0;
            o_pln_txt <= '0;
            o_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    data  <= ip(i_cipher_text);
                    k1    <= k1_of(i_key);
                    k2    <= k2_of(i_key);
                    state <= RND1;
                end
                RND1: begin
                    data  <= {fk_res[3:0], fk_res[7:4]};
                    state <= RND2;
                end
                RND2: begin
                    o_pln_txt <= ip_inv(fk_res);
                    o_valid   <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (i_ready) begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
